phy_rx_lane: RTL and testbench



---
 rtl/phy_rx_lane.sv | 175 +++++++++++++++++
 tb/tb_phy_rx_lane.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_lane.sv
// phy_rx_lane: single-lane receive deserializer.
//
// Hunts for byte alignment on the serial stream using COM_CHAR, locks after
// LOCK_COUNT consecutive aligned COM bytes, then assembles four data bytes
// (MSB first, first byte in [31:24]) into a 32-bit word.
//
// Ports:
//   clk_32f     in   bit clock, one serial bit per rising edge
//   reset       in   synchronous active-high reset
//   data_in     in   serial lane bit
//   data_out    out  [31:0] last assembled word, held between strobes
//   valid_out   out  one-cycle strobe, data_out holds a new word
//   active_lane out  high while locked (cleared only by reset)
//   word_err    out  one-cycle strobe, a partial word was discarded
//   err_count   out  [7:0] saturating error counter, only when PHY_RX_ERR_CNT_EN is defined
//
// Optional feature macro: PHY_RX_ERR_CNT_EN.

module phy_rx_lane #(
    parameter logic [7:0]  COM_CHAR   = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        active_lane,
    output logic        word_err
`ifdef PHY_RX_ERR_CNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [1:0] StSearch = 2'd0;
    localparam logic [1:0] StAlign  = 2'd1;
    localparam logic [1:0] StLocked = 2'd2;

    localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

    logic [1:0]  state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  com_cnt_q, com_cnt_d;
    logic [23:0] word_q, word_d;
    logic [31:0] data_out_q, data_out_d;
    logic        valid_q, valid_d;
    logic        active_q, active_d;
    logic        word_err_q, word_err_d;

    logic [7:0]  cur_byte;
    logic        boundary;
    logic        is_com;

    assign cur_byte = {sr_q[6:0], data_in};
    assign boundary = (bit_cnt_q == 3'd7);
    assign is_com   = (cur_byte == COM_CHAR);

    always_comb begin
        state_d    = state_q;
        sr_d       = cur_byte;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        byte_cnt_d = byte_cnt_q;
        com_cnt_d  = com_cnt_q;
        word_d     = word_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        active_d   = active_q;
        word_err_d = 1'b0;

        case (state_q)
            StSearch: begin
                // Bit hunt: any alignment is a candidate until COM is seen.
                if (is_com) begin
                    bit_cnt_d = 3'd0;
                    com_cnt_d = 4'd1;
                    state_d   = StAlign;
                end
            end
            StAlign: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_q + 4'd1 == LockCnt) begin
                            state_d  = StLocked;
                            active_d = 1'b1;
                        end
                    end else begin
                        com_cnt_d = 4'd0;
                        state_d   = StSearch;
                    end
                end
            end
            StLocked: begin
                if (boundary) begin
                    if (is_com) begin
                        // Idle inside a word means the transmitter abandoned it.
                        if (byte_cnt_q != 2'd0) begin
                            word_err_d = 1'b1;
                            byte_cnt_d = 2'd0;
                        end
                    end else begin
                        word_d = {word_q[15:0], cur_byte};
                        if (byte_cnt_q == 2'd3) begin
                            data_out_d = {word_q, cur_byte};
                            valid_d    = 1'b1;
                            byte_cnt_d = 2'd0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q    <= StSearch;
            sr_q       <= 8'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            com_cnt_q  <= 4'd0;
            word_q     <= 24'd0;
            data_out_q <= 32'd0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
            word_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            com_cnt_q  <= com_cnt_d;
            word_q     <= word_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
            word_err_q <= word_err_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_q;
    assign active_lane = active_q;
    assign word_err    = word_err_q;

`ifdef PHY_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       fallback;

    assign fallback = (state_q == StAlign) && boundary && !is_com;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((word_err_d || fallback) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_phy_rx_lane.sv
// Self-checking bench for phy_rx_lane: serial stimulus, scoreboard of expected
// words (with arrival cycle) and expected word_err strobes.
// Optional feature macro: PHY_RX_ERR_CNT_EN (adds err_count checks).

module tb_phy_rx_lane;

    localparam logic [7:0] COM  = 8'hBC;
    localparam int         LOCK = 4;

    logic        clk;
    logic        reset;
    logic        data_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        active_lane;
    logic        word_err;
`ifdef PHY_RX_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    phy_rx_lane #(
        .COM_CHAR   (COM),
        .LOCK_COUNT (LOCK)
    ) dut (
        .clk_32f     (clk),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .active_lane (active_lane),
        .word_err    (word_err)
`ifdef PHY_RX_ERR_CNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        int          idles;
        logic [31:0] word;
        logic [31:0] exp_data;
    } vec_t;

    exp_t sb_q[$];
    int   err_q[$];
    int   n_vec;
    int   n_err;
    int   cyc;
    int   act_cyc;
    logic act_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observe outputs produced by the previous rising edge.
    task automatic monitor();
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_valid: got none, want %h at cycle %0d", e.data, e.cyc);
        end
        if (err_q.size() > 0 && err_q[0] < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_word_err: got none, want strobe at cycle %0d", err_q[0]);
            void'(err_q.pop_front());
        end
        if (valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got data %h, want no strobe", data_out);
            end else begin
                e = sb_q.pop_front();
                chk("valid_data", data_out, e.data);
                chk("valid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (word_err === 1'b1) begin
            if (err_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word_err: got strobe, want none (cycle %0d)", cyc);
            end else begin
                chk("word_err_cycle", 32'(cyc), 32'(err_q[0]));
                void'(err_q.pop_front());
            end
        end
        if (valid_out === 1'b1 && word_err === 1'b1) begin
            n_err++;
            $display("FAIL strobe_overlap: got valid and word_err together, want exclusive");
        end
        if ((valid_out === 1'b1 || word_err === 1'b1) && active_lane !== 1'b1) begin
            n_err++;
            $display("FAIL strobe_unlocked: got strobe with active_lane=%b, want 1", active_lane);
        end
        if (cyc == act_cyc) chk("active_lane", 32'(active_lane), 32'(act_exp));
    endtask

    task automatic tick(input logic b, input logic r);
        @(negedge clk);
        cyc++;
        monitor();
        data_in = b;
        reset   = r;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tick(b[i], 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] exp_data);
        exp_t e;
        e.data = exp_data;
        e.cyc  = cyc + 1 + 32;
        sb_q.push_back(e);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    // Send n COM bytes; the LOCK-th must be the one that raises active_lane.
    task automatic lock_com(input int n);
        logic [7:0] c;
        c = COM;
        for (int i = 0; i < n; i++) begin
            if (i == LOCK - 1) begin
                for (int k = 7; k >= 1; k--) tick(c[k], 1'b0);
                tick(c[0], 1'b0);
                chk("active_pre_lock", 32'(active_lane), 32'd0);
                act_cyc = cyc + 1;
                act_exp = 1'b1;
            end else begin
                send_byte(c);
            end
        end
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b1);
    endtask

    task automatic drain(input string name);
        send_byte(COM);
        send_byte(COM);
        chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        chk({name, "_err_empty"}, 32'(err_q.size()), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        n_vec   = 0;
        n_err   = 0;
        cyc     = 0;
        act_cyc = -1;
        act_exp = 1'b0;
        data_in = 1'b0;
        reset   = 1'b1;

        vecs[0] = '{idles: 1, word: 32'hCAFEF00D, exp_data: 32'hCAFEF00D};
        vecs[1] = '{idles: 0, word: 32'h12345678, exp_data: 32'h12345678};
        vecs[2] = '{idles: 0, word: 32'hFFFFFFFF, exp_data: 32'hFFFFFFFF};
        vecs[3] = '{idles: 2, word: 32'h00000000, exp_data: 32'h00000000};
        vecs[4] = '{idles: 0, word: 32'h80018001, exp_data: 32'h80018001};
        vecs[5] = '{idles: 3, word: 32'h7E7E7E7E, exp_data: 32'h7E7E7E7E};

        // Reset held 3 cycles with toggling data.
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_active", 32'(active_lane), 32'd0);
        chk("rst_word_err", 32'(word_err), 32'd0);
`ifdef PHY_RX_ERR_CNT_EN
        chk("rst_err_count", 32'(err_count), 32'd0);
`endif

        // Basic lock and one word.
        do_reset();
        lock_com(4);
        send_word(32'hDEADBEEF, 32'hDEADBEEF);
        drain("deadbeef");

        // Misaligned start, longer COM run.
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        lock_com(6);
        send_word(32'h01020304, 32'h01020304);
        drain("misalign");

        // Table of words, some back-to-back (strobes 32 cycles apart).
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < vecs[v].idles; k++) send_byte(COM);
            send_word(vecs[v].word, vecs[v].exp_data);
        end
        drain("table");

        // Broken COM run falls back to search, then relocks.
        do_reset();
        send_byte(COM);
        send_byte(COM);
        send_byte(COM);
        send_byte(8'h12);
        act_cyc = cyc + 1;
        act_exp = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        lock_com(4);
`ifdef PHY_RX_ERR_CNT_EN
        chk("err_count_fallback", 32'(err_count), 32'd1);
`endif

        // Partial word aborted by idle.
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(COM);
        err_q.push_back(cyc + 1);
        send_word(32'hA1B2C3D4, 32'hA1B2C3D4);
        drain("word_err");
`ifdef PHY_RX_ERR_CNT_EN
        chk("err_count_word_err", 32'(err_count), 32'd2);
`endif

        // Mid-word reset drops lock and partial data.
        send_byte(8'h99);
        send_byte(8'hAA);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("midrst_active", 32'(active_lane), 32'd0);
        chk("midrst_data_out", data_out, 32'd0);
        lock_com(4);
        send_word(32'h55667788, 32'h55667788);
        drain("relock");
        chk("final_data_out", data_out, 32'h55667788);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
